// File: rtl/rmii_rx_byte_if.sv
// RMII receive byte-stream interface between the PHY-side pins and the parser.
// Optional crc_ok signal exists only when RMII_RX_CRC_CHECK_EN is defined.
//
// Byte stream: byte_valid is a one-cycle strobe with no back-pressure. The
// consumer must accept received_byte in the cycle byte_valid is high.
// received_byte holds its value between strobes. frame_end and frame_err are
// one-cycle strobes. frame_err is only ever high together with frame_end.
interface rmii_rx_byte_if;
  logic       crs_dv;
  logic [1:0] rxd;
  logic [7:0] received_byte;
  logic       byte_valid;
  logic       frame_active;
  logic       frame_end;
  logic       frame_err;
`ifdef RMII_RX_CRC_CHECK_EN
  logic       crc_ok;
`endif
  logic [1:0] dbg_state;

  modport master (
    output crs_dv, rxd,
    input  received_byte, byte_valid, frame_active, frame_end, frame_err,
    input  dbg_state
`ifdef RMII_RX_CRC_CHECK_EN
    , input crc_ok
`endif
  );

  modport slave (
    input  crs_dv, rxd,
    output received_byte, byte_valid, frame_active, frame_end, frame_err,
    output dbg_state
`ifdef RMII_RX_CRC_CHECK_EN
    , output crc_ok
`endif
  );
endinterface

// File: rtl/rmii_rx_byte.sv
// RMII receive front end: registers CRS_DV/RXD, finds the preamble, aligns on
// the SFD and assembles LSB-first dibits into bytes for the frame parser.
// Optional feature macro: RMII_RX_CRC_CHECK_EN adds a CRC-32 residue check (crc_ok).
module rmii_rx_byte #(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MAX_FRAME_BYTES     = 1522
) (
  input  logic          clk,
  input  logic          reset,
  rmii_rx_byte_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DISCARD  = 2'd3
  } state_t;

  localparam logic [10:0] MAX_BYTES = 11'(MAX_FRAME_BYTES);

  logic       r_crs_dv_q;
  logic [1:0] r_rxd_q;
  state_t     r_state,         w_state_n;
  logic [5:0] r_pre_cnt,       w_pre_cnt_n;
  logic [1:0] r_dib_cnt,       w_dib_cnt_n;
  logic [10:0] r_byte_cnt,     w_byte_cnt_n;
  logic [7:0] r_sr,            w_sr_n;
  logic       r_low,           w_low_n;       // crs_dv_q was 0 in the previous cycle
  logic       r_pend,          w_pend_n;      // byte completed on a low cycle, not yet emitted
  logic       r_err,           w_err_n;       // oversize error waiting to be reported
  logic [7:0] r_received_byte, w_received_byte_n;
  logic       r_byte_valid,    w_byte_valid_n;
  logic       r_frame_active,  w_frame_active_n;
  logic       r_frame_end,     w_frame_end_n;
  logic       r_frame_err,     w_frame_err_n;
  logic       w_emit;
  logic [7:0] w_emit_byte;
  logic [1:0] w_dib_eff;
`ifdef RMII_RX_CRC_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  logic [31:0] r_crc,    w_crc_n;
  logic        r_crc_ok, w_crc_ok_n;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction
`endif

  // Input register stage: all decoding works on the registered pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crs_dv_q <= 1'b0;
      r_rxd_q    <= 2'b00;
    end else begin
      r_crs_dv_q <= bus.crs_dv;
      r_rxd_q    <= bus.rxd;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_pre_cnt       <= 6'd0;
      r_dib_cnt       <= 2'd0;
      r_byte_cnt      <= 11'd0;
      r_sr            <= 8'd0;
      r_low           <= 1'b0;
      r_pend          <= 1'b0;
      r_err           <= 1'b0;
      r_received_byte <= 8'd0;
      r_byte_valid    <= 1'b0;
      r_frame_active  <= 1'b0;
      r_frame_end     <= 1'b0;
      r_frame_err     <= 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
      r_crc           <= 32'd0;
      r_crc_ok        <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_n;
      r_pre_cnt       <= w_pre_cnt_n;
      r_dib_cnt       <= w_dib_cnt_n;
      r_byte_cnt      <= w_byte_cnt_n;
      r_sr            <= w_sr_n;
      r_low           <= w_low_n;
      r_pend          <= w_pend_n;
      r_err           <= w_err_n;
      r_received_byte <= w_received_byte_n;
      r_byte_valid    <= w_byte_valid_n;
      r_frame_active  <= w_frame_active_n;
      r_frame_end     <= w_frame_end_n;
      r_frame_err     <= w_frame_err_n;
`ifdef RMII_RX_CRC_CHECK_EN
      r_crc           <= w_crc_n;
      r_crc_ok        <= w_crc_ok_n;
`endif
    end
  end

  // Next-state and output decode. A first low cycle in DATA is shifted in
  // speculatively (CRS_DV may just be toggling); if a second low follows, the
  // frame ends and that speculative dibit is discounted (w_dib_eff).
  always_comb begin
    w_state_n         = r_state;
    w_pre_cnt_n       = r_pre_cnt;
    w_dib_cnt_n       = r_dib_cnt;
    w_byte_cnt_n      = r_byte_cnt;
    w_sr_n            = r_sr;
    w_low_n           = ~r_crs_dv_q;
    w_pend_n          = r_pend;
    w_err_n           = r_err;
    w_received_byte_n = r_received_byte;
    w_byte_valid_n    = 1'b0;
    w_frame_active_n  = r_frame_active & ~r_frame_end;
    w_frame_end_n     = 1'b0;
    w_frame_err_n     = 1'b0;
    w_emit            = 1'b0;
    w_emit_byte       = r_sr;
    w_dib_eff         = r_dib_cnt - 2'd1;
`ifdef RMII_RX_CRC_CHECK_EN
    w_crc_n           = r_crc;
    w_crc_ok_n        = r_crc_ok;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_crs_dv_q && (r_rxd_q == 2'b01)) begin
          w_pre_cnt_n = 6'd1;
          w_state_n   = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (!r_crs_dv_q) begin
          w_state_n = S_IDLE;
        end else begin
          case (r_rxd_q)
            2'b01: if (r_pre_cnt != 6'd63) w_pre_cnt_n = r_pre_cnt + 6'd1;
            2'b11: begin
              if (32'(r_pre_cnt) >= MIN_PREAMBLE_DIBITS) begin
                w_received_byte_n = 8'hD5;
                w_byte_valid_n    = 1'b1;
                w_frame_active_n  = 1'b1;
                w_dib_cnt_n       = 2'd0;
                w_byte_cnt_n      = 11'd0;
                w_pend_n          = 1'b0;
                w_err_n           = 1'b0;
                w_state_n         = S_DATA;
`ifdef RMII_RX_CRC_CHECK_EN
                w_crc_n           = 32'hFFFFFFFF;
`endif
              end else begin
                w_state_n = S_DISCARD;
              end
            end
            2'b10:   w_state_n = S_DISCARD;
            default: ;
          endcase
        end
      end
      S_DATA: begin
        if (!r_crs_dv_q && r_low) begin
          w_frame_end_n = 1'b1;
          w_frame_err_n = (w_dib_eff != 2'd0) || (r_byte_cnt == 11'd0);
          w_pend_n      = 1'b0;
          w_state_n     = S_IDLE;
`ifdef RMII_RX_CRC_CHECK_EN
          w_crc_ok_n    = (r_crc == CRC_RESIDUE) && !w_frame_err_n;
`endif
        end else begin
          w_sr_n      = {r_rxd_q, r_sr[7:2]};
          w_dib_cnt_n = r_dib_cnt + 2'd1;
          if (r_pend) begin
            w_emit      = 1'b1;
            w_emit_byte = r_sr;
            w_pend_n    = 1'b0;
          end else if (r_dib_cnt == 2'd3) begin
            if (r_crs_dv_q) begin
              w_emit      = 1'b1;
              w_emit_byte = {r_rxd_q, r_sr[7:2]};
            end else begin
              w_pend_n = 1'b1;
            end
          end
          if (w_emit) begin
            if (r_byte_cnt < MAX_BYTES) begin
              w_received_byte_n = w_emit_byte;
              w_byte_valid_n    = 1'b1;
              if (r_byte_cnt != 11'h7FF) w_byte_cnt_n = r_byte_cnt + 11'd1;
`ifdef RMII_RX_CRC_CHECK_EN
              w_crc_n           = crc32_byte(r_crc, w_emit_byte);
`endif
            end else begin
              w_err_n   = 1'b1;
              w_pend_n  = 1'b0;
              w_state_n = S_DISCARD;
            end
          end
        end
      end
      S_DISCARD: begin
        if (!r_crs_dv_q && r_err) begin
          w_frame_end_n = 1'b1;
          w_frame_err_n = 1'b1;
          w_err_n       = 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
          w_crc_ok_n    = 1'b0;
`endif
        end
        if (!r_crs_dv_q && r_low) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.received_byte = r_received_byte;
  assign bus.byte_valid    = r_byte_valid;
  assign bus.frame_active  = r_frame_active;
  assign bus.frame_end     = r_frame_end;
  assign bus.frame_err     = r_frame_err;
  assign bus.dbg_state     = r_state;
`ifdef RMII_RX_CRC_CHECK_EN
  assign bus.crc_ok        = r_crc_ok;
`endif

endmodule

// File: tb/tb_rmii_rx_byte.sv
// Directed bench for rmii_rx_byte: one receiver with default limits (dut_a)
// and one with a 16-byte frame limit (dut_b), both fed the same pins.
module tb_rmii_rx_byte;

  logic       clk = 1'b0;
  logic       reset;
  logic       crs_dv;
  logic [1:0] rxd;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         a_stray = 0;

  // Clock / reset block
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rmii_rx_byte_if bus_a ();
  rmii_rx_byte_if bus_b ();
  assign bus_a.crs_dv = crs_dv;
  assign bus_a.rxd    = rxd;
  assign bus_b.crs_dv = crs_dv;
  assign bus_b.rxd    = rxd;

  rmii_rx_byte #(.MIN_PREAMBLE_DIBITS(8), .MAX_FRAME_BYTES(1522)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  rmii_rx_byte #(.MIN_PREAMBLE_DIBITS(8), .MAX_FRAME_BYTES(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Observed events, captured on the falling edge
  logic [7:0] a_bytes[$];
  int         a_stamp[$];
  logic       a_fa[$];
  logic       a_ferr[$];
  int         a_fe_stamp[$];
  logic       a_crc[$];
  logic [7:0] b_bytes[$];
  logic       b_ferr[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];
`ifdef RMII_RX_CRC_CHECK_EN
  logic [7:0]  pay[$];
  logic [31:0] crc_m;
`endif

  always @(negedge clk) begin
    if (bus_a.byte_valid) begin
      a_bytes.push_back(bus_a.received_byte);
      a_stamp.push_back(cyc);
      a_fa.push_back(bus_a.frame_active);
    end
    if (bus_a.frame_end) begin
      a_ferr.push_back(bus_a.frame_err);
      a_fe_stamp.push_back(cyc);
`ifdef RMII_RX_CRC_CHECK_EN
      a_crc.push_back(bus_a.crc_ok);
`endif
    end
    if (bus_a.frame_err && !bus_a.frame_end) a_stray++;
    if (bus_b.byte_valid) b_bytes.push_back(bus_b.received_byte);
    if (bus_b.frame_end) b_ferr.push_back(bus_b.frame_err);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // Scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input bit sel_b);
    int n;
    if (!sel_b) begin
      check({tag, "_count"}, a_bytes.size(), exp_q.size());
      n = (a_bytes.size() < exp_q.size()) ? a_bytes.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, a_bytes[i], exp_q[i]);
    end else begin
      check({tag, "_count"}, b_bytes.size(), exp_b_q.size());
      n = (b_bytes.size() < exp_b_q.size()) ? b_bytes.size() : exp_b_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, b_bytes[i], exp_b_q[i]);
    end
  endtask

  task automatic check_end_a(input string tag, input logic ferr);
    check({tag, "_ends"}, a_ferr.size(), 1);
    if (a_ferr.size() == 1) check({tag, "_err"}, a_ferr[0], ferr);
  endtask

  task automatic clear_mon();
    a_bytes.delete(); a_stamp.delete(); a_fa.delete(); a_ferr.delete();
    a_fe_stamp.delete(); a_crc.delete(); b_bytes.delete(); b_ferr.delete();
    exp_q.delete(); exp_b_q.delete();
  endtask

  // Driver tasks: one dibit per clock, applied on the falling edge
  task automatic dib(input logic c, input logic [1:0] d);
    @(negedge clk);
    crs_dv = c;
    rxd    = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) dib(1'b1, b[2*i +: 2]);
  endtask

  task automatic preamble(input int n);
    repeat (n) dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
  endtask

  task automatic end_frame();
    repeat (6) dib(1'b0, 2'b00);
  endtask

`ifdef RMII_RX_CRC_CHECK_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction
`endif

  initial begin
    reset  = 1'b1;
    crs_dv = 1'b0;
    rxd    = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_received_byte", bus_a.received_byte, 8'h00);
    check("rst_byte_valid", bus_a.byte_valid, 1'b0);
    check("rst_frame_active", bus_a.frame_active, 1'b0);
    check("rst_frame_end", bus_a.frame_end, 1'b0);
    check("rst_frame_err", bus_a.frame_err, 1'b0);
    check("rst_state", bus_a.dbg_state, 2'd0);
`ifdef RMII_RX_CRC_CHECK_EN
    check("rst_crc_ok", bus_a.crc_ok, 1'b0);
`endif
    reset = 1'b0;
    repeat (3) dib(1'b0, 2'b00);

    // Basic frame: 28 preamble dibits, SFD, 00 1A 2B
    clear_mon();
    exp_q = '{8'hD5, 8'h00, 8'h1A, 8'h2B};
    preamble(28);
    send_byte(8'h00); send_byte(8'h1A); send_byte(8'h2B);
    end_frame();
    check_bytes("frame", 1'b0);
    for (int i = 1; i < a_stamp.size(); i++) check("frame_gap", a_stamp[i] - a_stamp[i-1], 4);
    if (a_fa.size() > 0) check("frame_active_sfd", a_fa[0], 1'b1);
    check_end_a("frame", 1'b0);
    if (a_stamp.size() == 4 && a_fe_stamp.size() == 1)
      check("frame_end_gap", a_fe_stamp[0] - a_stamp[3], 2);
    check("frame_hold", bus_a.received_byte, 8'h2B);
    check("frame_active_after", bus_a.frame_active, 1'b0);

    // Short preamble is discarded, then an exactly-minimum preamble is accepted
    clear_mon();
    preamble(4);
    send_byte(8'h77);
    end_frame();
    check("short_bytes", a_bytes.size(), 0);
    check("short_ends", a_ferr.size(), 0);
    exp_q = '{8'hD5, 8'h3C};
    preamble(8);
    send_byte(8'h3C);
    end_frame();
    check_bytes("after_short", 1'b0);
    check_end_a("after_short", 1'b0);

    // Dribble: one byte plus two stray dibits
    clear_mon();
    exp_q = '{8'hD5, 8'h5A};
    preamble(28);
    send_byte(8'h5A);
    dib(1'b1, 2'b10); dib(1'b1, 2'b01);
    end_frame();
    check_bytes("dribble", 1'b0);
    check_end_a("dribble", 1'b1);

    // CRS_DV toggling once per nibble during the last byte (A5 = dibits 01,01,10,10)
    clear_mon();
    exp_q = '{8'hD5, 8'h11, 8'hA5};
    preamble(28);
    send_byte(8'h11);
    dib(1'b0, 2'b01); dib(1'b1, 2'b01); dib(1'b0, 2'b10); dib(1'b1, 2'b10);
    end_frame();
    check_bytes("toggle", 1'b0);
    check_end_a("toggle", 1'b0);

    // Oversize: 20 bytes; dut_b stops after 16, dut_a takes all
    clear_mon();
    exp_q.push_back(8'hD5);
    exp_b_q.push_back(8'hD5);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 16; i++) exp_b_q.push_back(8'(i));
    preamble(28);
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    check("oversize_no_end_yet", b_ferr.size(), 0);
    end_frame();
    check_bytes("oversize_b", 1'b1);
    check("oversize_b_ends", b_ferr.size(), 1);
    if (b_ferr.size() == 1) check("oversize_b_err", b_ferr[0], 1'b1);
    check_bytes("oversize_a", 1'b0);
    check_end_a("oversize_a", 1'b0);

    // Reset in the middle of DATA
    clear_mon();
    exp_q = '{8'hD5, 8'h42};
    preamble(28);
    send_byte(8'h42);
    dib(1'b1, 2'b01); dib(1'b1, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_received_byte", bus_a.received_byte, 8'h00);
    check("rstmid_byte_valid", bus_a.byte_valid, 1'b0);
    check("rstmid_frame_active", bus_a.frame_active, 1'b0);
    check("rstmid_frame_end", bus_a.frame_end, 1'b0);
    check("rstmid_state", bus_a.dbg_state, 2'd0);
    reset = 1'b0;
    end_frame();
    check_bytes("rstmid", 1'b0);
    check("rstmid_ends", a_ferr.size(), 0);

`ifdef RMII_RX_CRC_CHECK_EN
    // 64-byte frame with a good FCS, then the same frame with one bit flipped
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i * 37 + 5));
    crc_m = 32'hFFFFFFFF;
    foreach (pay[i]) crc_m = crc_upd(crc_m, pay[i]);
    crc_m = ~crc_m;
    pay.push_back(crc_m[7:0]);   pay.push_back(crc_m[15:8]);
    pay.push_back(crc_m[23:16]); pay.push_back(crc_m[31:24]);
    for (int pass = 0; pass < 2; pass++) begin
      clear_mon();
      if (pass == 1) pay[10] = pay[10] ^ 8'h01;
      exp_q.push_back(8'hD5);
      foreach (pay[i]) exp_q.push_back(pay[i]);
      preamble(8);
      foreach (pay[i]) send_byte(pay[i]);
      end_frame();
      check_bytes("crc_frame", 1'b0);
      check_end_a("crc_frame", 1'b0);
      check("crc_ok_count", a_crc.size(), 1);
      if (a_crc.size() == 1) check("crc_ok", a_crc[0], (pass == 0) ? 1'b1 : 1'b0);
    end
`endif

    check("stray_frame_err", a_stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
